req_pending_dispatcher: RTL and testbench

Sits directly upstream of the 4-input priority encoder stage. It captures request events from four raw request lines into a sticky pending register and resolves them by fixed priority, with req[3] highest. It then presents one served line index at a time to a consumer over a valid/ack handshake. Each served bit is cleared when it is loaded into the output, so every request event is delivered exactly once; dropped events are flagged.

---
 rtl/req_pending_dispatcher.sv | 130 +++++++++++++
 tb/tb_req_pending_dispatcher.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/req_pending_dispatcher.sv
// req_pending_dispatcher
// Captures request events from four raw lines into a sticky pending register,
// resolves them by fixed priority (req[3] highest) and hands one line index
// at a time to a consumer over a valid/ack handshake. A pending bit is
// cleared on the edge its index is loaded into idx, so each event is
// delivered once; an event that lands on an already-pending line is flagged
// in the sticky overrun register.
module req_pending_dispatcher #(
    parameter int EDGE_DET = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] mask,
    input  logic       ack,
    input  logic       clr_ovr,
    output logic       valid,
    output logic [1:0] idx,
    output logic [3:0] pending,
    output logic       any,
    output logic [3:0] overrun
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_reg;
    logic [3:0] req_q;
    logic [3:0] pending_reg;
    logic [3:0] overrun_reg;
    logic [1:0] idx_reg;
    logic       valid_reg;

    logic [3:0] ev;
    logic [3:0] clr;
    logic [3:0] pending_next;
    logic [3:0] overrun_next;
    logic [1:0] sel;
    logic       load;

    // Per-line event detection and overrun update.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_line
            if (EDGE_DET != 0) begin : g_edge
                assign ev[gi] = mask[gi] & req[gi] & ~req_q[gi];
            end else begin : g_level
                assign ev[gi] = mask[gi] & req[gi];
            end

            // A new event on a line that is pending and not being served now
            // is an overrun; that set takes precedence over clr_ovr.
            assign overrun_next[gi] = (ev[gi] & pending_reg[gi] & ~clr[gi]) ? 1'b1 :
                                      clr_ovr                               ? 1'b0 :
                                                                              overrun_reg[gi];
        end
    endgenerate

    // Highest set bit of the registered pending vector, same as the downstream encoder.
    always_comb begin
        sel = 2'd0;
        if (pending_reg[3]) begin
            sel = 2'd3;
        end else if (pending_reg[2]) begin
            sel = 2'd2;
        end else if (pending_reg[1]) begin
            sel = 2'd1;
        end else begin
            sel = 2'd0;
        end
    end

    // A new index is loaded whenever the output slot is free (idle or being acked)
    // and something is pending; the loaded line's pending bit is cleared.
    assign load         = (pending_reg != 4'd0) && ((state_reg == IDLE) || ack);
    assign clr          = load ? (4'b0001 << sel) : 4'b0000;
    assign pending_next = (pending_reg & ~clr) | ev;

    // Request history tracks the raw lines even during reset, so a line held
    // high across reset release does not look like a fresh edge.
    always_ff @(posedge clk) begin
        req_q <= req;
    end

    // Pending/overrun capture and the grant FSM with registered valid/idx.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_reg <= 4'd0;
            overrun_reg <= 4'd0;
            idx_reg     <= 2'd0;
            valid_reg   <= 1'b0;
            state_reg   <= IDLE;
        end else begin
            pending_reg <= pending_next;
            overrun_reg <= overrun_next;
            case (state_reg)
                IDLE: begin
                    if (load) begin
                        idx_reg   <= sel;
                        valid_reg <= 1'b1;
                        state_reg <= GRANT;
                    end
                end
                GRANT: begin
                    if (ack) begin
                        if (load) begin
                            idx_reg   <= sel;
                            valid_reg <= 1'b1;
                        end else begin
                            valid_reg <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end
                end
                default: begin
                    valid_reg <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign valid   = valid_reg;
    assign idx     = idx_reg;
    assign pending = pending_reg;
    assign any     = |pending_reg;
    assign overrun = overrun_reg;

endmodule

// File: tb/tb_req_pending_dispatcher.sv
// Testbench for req_pending_dispatcher: a hand-derived vector table for the
// edge-detect build, a hand-written level-mode sequence, and a randomized
// run of both builds against a behavioural model.
module tb_req_pending_dispatcher;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] mask;
    logic       ack;
    logic       clr_ovr;

    logic       valid_e, valid_l;
    logic [1:0] idx_e, idx_l;
    logic [3:0] pending_e, pending_l;
    logic       any_e, any_l;
    logic [3:0] overrun_e, overrun_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    req_pending_dispatcher #(.EDGE_DET(1)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .ack(ack), .clr_ovr(clr_ovr),
        .valid(valid_e), .idx(idx_e), .pending(pending_e), .any(any_e), .overrun(overrun_e)
    );

    req_pending_dispatcher #(.EDGE_DET(0)) dut_lvl (
        .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .ack(ack), .clr_ovr(clr_ovr),
        .valid(valid_l), .idx(idx_l), .pending(pending_l), .any(any_l), .overrun(overrun_l)
    );

    // One record = inputs applied for one clock edge + outputs required after it.
    typedef struct {
        bit       rst_n;
        bit [3:0] req;
        bit [3:0] mask;
        bit       ack;
        bit       clr;
        bit       ev;
        bit [1:0] ei;
        bit [3:0] ep;
        bit [3:0] eo;
    } vec_t;

    localparam int NVEC = 34;
    vec_t tbl [NVEC];

    function automatic vec_t mk(bit r, bit [3:0] q, bit [3:0] m, bit a, bit c,
                                bit v, bit [1:0] i, bit [3:0] p, bit [3:0] o);
        vec_t t;
        t.rst_n = r; t.req = q; t.mask = m; t.ack = a; t.clr = c;
        t.ev = v; t.ei = i; t.ep = p; t.eo = o;
        return t;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: [0] edge-detect build, [1] level build.
    bit [3:0] m_pend [2];
    bit [3:0] m_ovr  [2];
    bit [3:0] m_prev [2];
    bit       m_busy [2];
    int       m_idx  [2];

    task automatic model_step(int k);
        bit [3:0] evv;
        bit       free;
        bit       taken;
        int       take;
        if (!rst_n) begin
            m_pend[k] = 4'd0;
            m_ovr[k]  = 4'd0;
            m_busy[k] = 1'b0;
            m_idx[k]  = 0;
            m_prev[k] = req;
            return;
        end
        for (int i = 0; i < 4; i++) begin
            if (k == 0) evv[i] = mask[i] && req[i] && !m_prev[k][i];
            else        evv[i] = mask[i] && req[i];
        end
        // The output slot frees up when empty or when the consumer takes it.
        free = !m_busy[k] || ack;
        take = -1;
        if (free) begin
            for (int i = 3; i >= 0; i--) begin
                if (take < 0 && m_pend[k][i]) take = i;
            end
            if (take >= 0) begin
                m_busy[k] = 1'b1;
                m_idx[k]  = take;
            end else begin
                m_busy[k] = 1'b0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            taken = (i == take);
            if (evv[i] && m_pend[k][i] && !taken) m_ovr[k][i] = 1'b1;
            else if (clr_ovr)                     m_ovr[k][i] = 1'b0;
            m_pend[k][i] = (m_pend[k][i] && !taken) || evv[i];
        end
        m_prev[k] = req;
    endtask

    bit model_on = 1'b0;

    // Advance one clock edge, update the model on the edge, sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        if (model_on) begin
            model_step(0);
            model_step(1);
        end
        #1;
    endtask

    task automatic drive(bit r, bit [3:0] q, bit [3:0] m, bit a, bit c);
        rst_n = r; req = q; mask = m; ack = a; clr_ovr = c;
    endtask

    initial begin
        drive(1'b0, 4'd0, 4'hF, 1'b0, 1'b0);

        //                 rst  req      mask     ack  clr   valid idx  pending  overrun
        tbl[0]  = mk(1'b0, 4'b0000, 4'hF,    1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
        // single pulse on req[2], then served and acked
        tbl[1]  = mk(1'b1, 4'b0100, 4'hF,    1'b0, 1'b0, 1'b0, 2'd0, 4'b0100, 4'b0000);
        tbl[2]  = mk(1'b1, 4'b0000, 4'hF,    1'b1, 1'b0, 1'b1, 2'd2, 4'b0000, 4'b0000);
        tbl[3]  = mk(1'b1, 4'b0000, 4'hF,    1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 4'b0000);
        // three lines at once, ack tied high: 3,1,0 back to back
        tbl[4]  = mk(1'b1, 4'b1011, 4'hF,    1'b1, 1'b0, 1'b0, 2'd2, 4'b1011, 4'b0000);
        tbl[5]  = mk(1'b1, 4'b1011, 4'hF,    1'b1, 1'b0, 1'b1, 2'd3, 4'b0011, 4'b0000);
        tbl[6]  = mk(1'b1, 4'b1011, 4'hF,    1'b1, 1'b0, 1'b1, 2'd1, 4'b0001, 4'b0000);
        tbl[7]  = mk(1'b1, 4'b1011, 4'hF,    1'b1, 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000);
        tbl[8]  = mk(1'b1, 4'b1011, 4'hF,    1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
        tbl[9]  = mk(1'b1, 4'b0000, 4'hF,    1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
        // masked line 3: no capture
        tbl[10] = mk(1'b1, 4'b1000, 4'b0111, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
        tbl[11] = mk(1'b1, 4'b0000, 4'b0111, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
        // captured with mask open, then mask closed: still granted
        tbl[12] = mk(1'b1, 4'b1000, 4'hF,    1'b0, 1'b0, 1'b0, 2'd0, 4'b1000, 4'b0000);
        tbl[13] = mk(1'b1, 4'b0000, 4'b0111, 1'b0, 1'b0, 1'b1, 2'd3, 4'b0000, 4'b0000);
        tbl[14] = mk(1'b1, 4'b0000, 4'hF,    1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000);
        // grant idx 0 with ack low, then repeated req[0] pulses -> overrun
        tbl[15] = mk(1'b1, 4'b0001, 4'hF,    1'b0, 1'b0, 1'b0, 2'd3, 4'b0001, 4'b0000);
        tbl[16] = mk(1'b1, 4'b0000, 4'hF,    1'b0, 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000);
        tbl[17] = mk(1'b1, 4'b0001, 4'hF,    1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 4'b0000);
        tbl[18] = mk(1'b1, 4'b0000, 4'hF,    1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 4'b0000);
        tbl[19] = mk(1'b1, 4'b0001, 4'hF,    1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 4'b0001);
        tbl[20] = mk(1'b1, 4'b0000, 4'hF,    1'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 4'b0000);
        tbl[21] = mk(1'b1, 4'b0001, 4'hF,    1'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 4'b0001);
        tbl[22] = mk(1'b1, 4'b0000, 4'hF,    1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 4'b0001);
        tbl[23] = mk(1'b1, 4'b0000, 4'hF,    1'b1, 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0001);
        tbl[24] = mk(1'b1, 4'b0000, 4'hF,    1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0001);
        tbl[25] = mk(1'b1, 4'b0000, 4'hF,    1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000);
        // req[1] held high through reset release: no event
        tbl[26] = mk(1'b0, 4'b0010, 4'hF,    1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
        tbl[27] = mk(1'b1, 4'b0010, 4'hF,    1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
        tbl[28] = mk(1'b1, 4'b0010, 4'hF,    1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
        // build valid=1 with pending=0101, then reset mid-grant
        tbl[29] = mk(1'b1, 4'b0101, 4'hF,    1'b0, 1'b0, 1'b0, 2'd0, 4'b0101, 4'b0000);
        tbl[30] = mk(1'b1, 4'b0000, 4'hF,    1'b0, 1'b0, 1'b1, 2'd2, 4'b0001, 4'b0000);
        tbl[31] = mk(1'b1, 4'b0100, 4'hF,    1'b0, 1'b0, 1'b1, 2'd2, 4'b0101, 4'b0000);
        tbl[32] = mk(1'b0, 4'b0000, 4'hF,    1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
        tbl[33] = mk(1'b1, 4'b0000, 4'hF,    1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);

        // Table phase (edge-detect build only)
        for (int n = 0; n < NVEC; n++) begin
            drive(tbl[n].rst_n, tbl[n].req, tbl[n].mask, tbl[n].ack, tbl[n].clr);
            step();
            $display("vec %0d: req=%b mask=%b ack=%b clr=%b -> valid=%b idx=%0d pending=%b overrun=%b",
                     n, req, mask, ack, clr_ovr, valid_e, idx_e, pending_e, overrun_e);
            chk($sformatf("vec%0d valid", n),   valid_e,   tbl[n].ev);
            chk($sformatf("vec%0d idx", n),     idx_e,     tbl[n].ei);
            chk($sformatf("vec%0d pending", n), pending_e, tbl[n].ep);
            chk($sformatf("vec%0d overrun", n), overrun_e, tbl[n].eo);
            chk($sformatf("vec%0d any", n),     any_e,     (tbl[n].ep != 4'd0) ? 1 : 0);
        end

        // Level-mode sequence: req[1] held high, ack low
        drive(1'b0, 4'b0000, 4'hF, 1'b0, 1'b0);
        step();
        chk("lvl reset valid", valid_l, 0);
        chk("lvl reset pending", pending_l, 0);
        drive(1'b1, 4'b0010, 4'hF, 1'b0, 1'b0);
        step();
        $display("lvl cap:   valid=%b idx=%0d pending=%b overrun=%b", valid_l, idx_l, pending_l, overrun_l);
        chk("lvl cap pending", pending_l, 4'b0010);
        chk("lvl cap valid", valid_l, 0);
        step();
        $display("lvl load:  valid=%b idx=%0d pending=%b overrun=%b", valid_l, idx_l, pending_l, overrun_l);
        chk("lvl load valid", valid_l, 1);
        chk("lvl load idx", idx_l, 1);
        chk("lvl load repend", pending_l, 4'b0010);
        chk("lvl load overrun", overrun_l, 0);
        step();
        $display("lvl hold:  valid=%b idx=%0d pending=%b overrun=%b", valid_l, idx_l, pending_l, overrun_l);
        chk("lvl hold overrun", overrun_l, 4'b0010);
        chk("lvl hold valid", valid_l, 1);
        chk("lvl hold idx", idx_l, 1);

        // Randomized phase, both builds against the model
        model_on = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            drive((n == 0) ? 1'b0 : ($urandom_range(0, 63) != 0),
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF,
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0));
            step();
            if (n % 100 == 0)
                $display("rnd %0d: req=%b ack=%b -> edge v=%b i=%0d p=%b o=%b | level v=%b i=%0d p=%b o=%b",
                         n, req, ack, valid_e, idx_e, pending_e, overrun_e,
                         valid_l, idx_l, pending_l, overrun_l);
            chk($sformatf("rnd%0d edge valid", n),   valid_e,   m_busy[0]);
            chk($sformatf("rnd%0d edge idx", n),     idx_e,     m_idx[0]);
            chk($sformatf("rnd%0d edge pending", n), pending_e, m_pend[0]);
            chk($sformatf("rnd%0d edge overrun", n), overrun_e, m_ovr[0]);
            chk($sformatf("rnd%0d edge any", n),     any_e,     (m_pend[0] != 0) ? 1 : 0);
            chk($sformatf("rnd%0d lvl valid", n),    valid_l,   m_busy[1]);
            chk($sformatf("rnd%0d lvl idx", n),      idx_l,     m_idx[1]);
            chk($sformatf("rnd%0d lvl pending", n),  pending_l, m_pend[1]);
            chk($sformatf("rnd%0d lvl overrun", n),  overrun_l, m_ovr[1]);
            chk($sformatf("rnd%0d lvl any", n),      any_l,     (m_pend[1] != 0) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
